// File: rtl/hack_exec_ctrl.sv
// hack_exec_ctrl
//   Execute/control stage wrapped around the combinational 16-bit Hack ALU.
//   Accepts instructions over a valid/ready handshake, holds the A, D and PC
//   registers, drives the ALU operands/control, and consumes the ALU result
//   for register writeback, memory writes and jump resolution.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   instr, instr_valid    instruction word and its valid strobe
//   instr_ready           high in FETCH: an instruction can be accepted
//   in_m                  memory read data at address a_reg (stable in EXEC)
//   alu_x, alu_y, alu_ctl ALU operands and {zx,nx,zy,ny,f,no}
//   alu_out, alu_zr, alu_ng  ALU result and flags
//   out_m, address_m      registered memory write data / address
//   write_m, m_ack        memory write request / acceptance
//   pc, a_reg, d_reg      architectural registers
module hack_exec_ctrl #(
    parameter int unsigned         PC_WIDTH = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [15:0]         in_m,
    output logic [15:0]         alu_x,
    output logic [15:0]         alu_y,
    output logic [5:0]          alu_ctl,
    input  logic [15:0]         alu_out,
    input  logic                alu_zr,
    input  logic                alu_ng,
    output logic [15:0]         out_m,
    output logic [PC_WIDTH-1:0] address_m,
    output logic                write_m,
    input  logic                m_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         a_reg,
    output logic [15:0]         d_reg
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WMEM  = 2'd2
    } state_t;

    state_t              state_q;
    // Only the C-instruction fields that matter are held; bit 15 is implied
    // by being in EXEC and bits 14:13 carry no meaning.
    logic [12:0]         ir_q;
    logic [15:0]         a_q;
    logic [15:0]         d_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [15:0]         out_m_q;
    logic [PC_WIDTH-1:0] address_m_q;
    logic                write_m_q;
    logic                instr_ready_q;

    logic [PC_WIDTH-1:0] pc_inc_d;
    logic                jump_d;
    logic [PC_WIDTH-1:0] pc_exec_d;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^instr[14:13];

    // Operands and control are driven in every state; only EXEC uses the result.
    assign alu_x   = d_q;
    assign alu_y   = ir_q[12] ? in_m : a_q;
    assign alu_ctl = ir_q[11:6];

    assign pc_inc_d  = pc_q + PC_WIDTH'(1);
    assign jump_d    = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) |
                       (ir_q[0] & ~alu_ng & ~alu_zr);
    // Jump target is the A value from before this instruction's writeback.
    assign pc_exec_d = jump_d ? a_q[PC_WIDTH-1:0] : pc_inc_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            ir_q          <= '0;
            a_q           <= '0;
            d_q           <= '0;
            pc_q          <= RESET_PC;
            out_m_q       <= '0;
            address_m_q   <= '0;
            write_m_q     <= 1'b0;
            instr_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (instr_valid && instr_ready_q) begin
                        if (instr[15]) begin
                            ir_q          <= instr[12:0];
                            state_q       <= EXEC;
                            instr_ready_q <= 1'b0;
                        end else begin
                            a_q  <= instr;
                            pc_q <= pc_inc_d;
                        end
                    end
                end
                EXEC: begin
                    if (ir_q[5]) a_q <= alu_out;
                    if (ir_q[4]) d_q <= alu_out;
                    pc_q <= pc_exec_d;
                    if (ir_q[3]) begin
                        out_m_q     <= alu_out;
                        address_m_q <= a_q[PC_WIDTH-1:0];
                        write_m_q   <= 1'b1;
                        state_q     <= WMEM;
                    end else begin
                        state_q       <= FETCH;
                        instr_ready_q <= 1'b1;
                    end
                end
                WMEM: begin
                    if (m_ack) begin
                        write_m_q     <= 1'b0;
                        state_q       <= FETCH;
                        instr_ready_q <= 1'b1;
                    end
                end
                default: begin
                    write_m_q     <= 1'b0;
                    state_q       <= FETCH;
                    instr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign out_m       = out_m_q;
    assign address_m   = address_m_q;
    assign write_m     = write_m_q;
    assign pc          = pc_q;
    assign a_reg       = a_q;
    assign d_reg       = d_q;

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Testbench for hack_exec_ctrl: directed instruction vectors with
// hand-computed results, a Hack ALU model closing the loop, an m_ack
// responder, and a queue-based monitor that checks register state after
// each instruction, EXEC-phase ALU drive, and memory write transactions.
module tb_hack_exec_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] in_m;
    logic [15:0] alu_x, alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [15:0] out_m;
    logic [14:0] address_m;
    logic        write_m;
    logic        m_ack;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;

    always #5 clock = ~clock;

    hack_exec_ctrl #(.PC_WIDTH(15), .RESET_PC(15'd0)) dut (
        .clock(clock), .reset(reset),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .in_m(in_m),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .out_m(out_m), .address_m(address_m), .write_m(write_m), .m_ack(m_ack),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
    );

    // Hack ALU model
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = alu_x;
        if (alu_ctl[5]) ax = '0;
        if (alu_ctl[4]) ax = ~ax;
        ay = alu_y;
        if (alu_ctl[3]) ay = '0;
        if (alu_ctl[2]) ay = ~ay;
        ao = alu_ctl[1] ? (ax + ay) : (ax & ay);
        if (alu_ctl[0]) ao = ~ao;
        alu_out = ao;
        alu_zr  = (ao == 16'h0000);
        alu_ng  = ao[15];
    end

    typedef struct { logic [15:0] a; logic [15:0] d; logic [14:0] pc; } reg_exp_t;
    typedef struct { logic [5:0] ctl; logic [15:0] y; } exe_exp_t;
    typedef struct { logic [15:0] dout; logic [14:0] addr; int dur; } wr_exp_t;

    reg_exp_t reg_q[$];
    exe_exp_t exe_q[$];
    wr_exp_t  wr_q[$];

    int checks   = 0;
    int failures = 0;
    int ack_wait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // m_ack responder: acks after ack_wait low cycles of write_m.
    initial begin
        int wcnt;
        wcnt  = 0;
        m_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (write_m && !reset) begin
                m_ack = (wcnt >= ack_wait);
                wcnt++;
            end else begin
                m_ack = 1'b0;
                wcnt  = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit       pending, pend_c, wr_act;
        int       cnt, wr_cyc;
        reg_exp_t r;
        exe_exp_t e;
        pending = 0; pend_c = 0; wr_act = 0; cnt = 0; wr_cyc = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pending = 0; wr_act = 0; wr_cyc = 0;
                reg_q.delete(); exe_q.delete(); wr_q.delete();
                continue;
            end
            if (write_m) begin
                if (wr_q.size() == 0) chk("unexpected_write", {31'b0, write_m}, 32'd0);
                else begin
                    chk("out_m", {16'b0, out_m}, {16'b0, wr_q[0].dout});
                    chk("address_m", {17'b0, address_m}, {17'b0, wr_q[0].addr});
                end
                wr_act = 1;
                wr_cyc++;
            end else if (wr_act) begin
                if (wr_q.size() > 0) begin
                    chk("write_cycles", wr_cyc, wr_q[0].dur);
                    void'(wr_q.pop_front());
                end
                wr_act = 0;
                wr_cyc = 0;
            end
            if (pending) begin
                if (cnt == 0 && pend_c && exe_q.size() > 0) begin
                    e = exe_q.pop_front();
                    chk("exec_ready", {31'b0, instr_ready}, 32'd0);
                    chk("alu_ctl", {26'b0, alu_ctl}, {26'b0, e.ctl});
                    chk("alu_y", {16'b0, alu_y}, {16'b0, e.y});
                end
                if (instr_ready) begin
                    if (reg_q.size() > 0) begin
                        r = reg_q.pop_front();
                        chk("a_reg", {16'b0, a_reg}, {16'b0, r.a});
                        chk("d_reg", {16'b0, d_reg}, {16'b0, r.d});
                        chk("pc", {17'b0, pc}, {17'b0, r.pc});
                        chk("write_m_idle", {31'b0, write_m}, 32'd0);
                    end
                    pending = 0;
                end else begin
                    cnt++;
                    if (cnt > 200) begin
                        chk("completion_timeout", cnt, 32'd0);
                        pending = 0;
                        if (reg_q.size() > 0) void'(reg_q.pop_front());
                    end
                end
            end
            if (instr_valid && instr_ready) begin
                pending = 1;
                pend_c  = instr[15];
                cnt     = 0;
            end
        end
    end

    task automatic send(input logic [15:0] ins, input logic [15:0] ea, input logic [15:0] ed,
                        input logic [14:0] epc, input logic [15:0] ey, input bit wr,
                        input logic [15:0] wout, input logic [14:0] waddr, input int await);
        reg_exp_t r;
        exe_exp_t e;
        wr_exp_t  w;
        bit       ok;
        r.a = ea; r.d = ed; r.pc = epc;
        reg_q.push_back(r);
        if (ins[15]) begin
            e.ctl = ins[11:6]; e.y = ey;
            exe_q.push_back(e);
        end
        if (wr) begin
            ack_wait = await;
            w.dout = wout; w.addr = waddr; w.dur = await + 1;
            wr_q.push_back(w);
        end
        instr       = ins;
        instr_valid = 1'b1;
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (instr_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", {31'b0, instr_ready}, 32'd1);
        @(posedge clock);
        #1 instr_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, {17'b0, pc}, 32'd0);
        chk({tag, "_a"}, {16'b0, a_reg}, 32'd0);
        chk({tag, "_d"}, {16'b0, d_reg}, 32'd0);
        chk({tag, "_write_m"}, {31'b0, write_m}, 32'd0);
        chk({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
        chk({tag, "_out_m"}, {16'b0, out_m}, 32'd0);
        chk({tag, "_address_m"}, {17'b0, address_m}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; instr = '0; instr_valid = 1'b0; in_m = 16'h1234;
        #3 chk_reset("por");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        //    instr     a        d        pc       alu_y   wr out      addr    ack
        send(16'h0005, 16'h0005, 16'h0000, 15'd1,  16'h0,  0, 16'h0,   15'd0,  0);
        send(16'hEC10, 16'h0005, 16'h0005, 15'd2,  16'h5,  0, 16'h0,   15'd0,  0); // D=A
        send(16'h0064, 16'h0064, 16'h0005, 15'd3,  16'h0,  0, 16'h0,   15'd0,  0);
        send(16'hE7C8, 16'h0064, 16'h0005, 15'd4,  16'h64, 1, 16'h6,   15'd100, 3); // M=D+1
        send(16'h0014, 16'h0014, 16'h0005, 15'd5,  16'h0,  0, 16'h0,   15'd0,  0);
        send(16'hEA90, 16'h0014, 16'h0000, 15'd6,  16'h14, 0, 16'h0,   15'd0,  0); // D=0
        send(16'hE302, 16'h0014, 16'h0000, 15'd20, 16'h14, 0, 16'h0,   15'd0,  0); // D;JEQ taken
        send(16'hEFD0, 16'h0014, 16'h0001, 15'd21, 16'h14, 0, 16'h0,   15'd0,  0); // D=1
        send(16'hE302, 16'h0014, 16'h0001, 15'd22, 16'h14, 0, 16'h0,   15'd0,  0); // D;JEQ not taken
        send(16'hEE90, 16'h0014, 16'hFFFF, 15'd23, 16'h14, 0, 16'h0,   15'd0,  0); // D=-1
        send(16'hE304, 16'h0014, 16'hFFFF, 15'd20, 16'h14, 0, 16'h0,   15'd0,  0); // D;JLT taken
        send(16'hE7E7, 16'h0000, 16'hFFFF, 15'd20, 16'h14, 0, 16'h0,   15'd0,  0); // A=D+1;JMP -> old A
        send(16'h0032, 16'h0032, 16'hFFFF, 15'd21, 16'h0,  0, 16'h0,   15'd0,  0);
        send(16'hE3A8, 16'hFFFE, 16'hFFFF, 15'd22, 16'h32, 1, 16'hFFFE, 15'd50, 0); // AM=D-1
        send(16'hFC10, 16'hFFFE, 16'h1234, 15'd23, 16'h1234, 0, 16'h0, 15'd0,  0); // D=M
        send(16'h7FFF, 16'h7FFF, 16'h1234, 15'd24, 16'h0,  0, 16'h0,   15'd0,  0);
        send(16'hEA87, 16'h7FFF, 16'h1234, 15'h7FFF, 16'h7FFF, 0, 16'h0, 15'd0, 0); // 0;JMP
        send(16'h0003, 16'h0003, 16'h1234, 15'd0,  16'h0,  0, 16'h0,   15'd0,  0); // pc wraps
        send(16'hE7C8, 16'h0003, 16'h1234, 15'd1,  16'h3,  1, 16'h1235, 15'd3, 100); // aborted by reset

        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (write_m) begin seen = 1; break; end
        end
        chk("wmem_reached", {31'b0, seen}, 32'd1);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 chk_reset("wmem_rst");
        @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;

        send(16'h0007, 16'h0007, 16'h0000, 15'd1, 16'h0, 0, 16'h0, 15'd0, 0);

        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (reg_q.size() == 0 && exe_q.size() == 0 && wr_q.size() == 0) break;
        end
        chk("queues_drained", reg_q.size() + exe_q.size() + wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hack_exec_ctrl.md
# hack_exec_ctrl

Sequential execute/control stage for the 16-bit Hack datapath. It accepts instructions over a valid/ready handshake and holds the A, D and PC registers. It drives the combinational ALU's operands and six control bits, then consumes the ALU's out/zr/ng to do register writeback, memory writes and jump resolution. It sits directly around the ALU: it is upstream for operands and control, and downstream for results.

## Interface
Parameters:
- PC_WIDTH, 15, width of pc and address_m
- RESET_PC, 0, pc value after reset

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr  in  16  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  block can accept an instruction
- in_m  in  16  memory read data at address a_reg; must be stable during EXEC
- alu_x  out  16  ALU x operand, always d_reg
- alu_y  out  16  ALU y operand: in_m if ir[12] else a_reg
- alu_ctl  out  6  {zx,nx,zy,ny,f,no} = ir[11:6]
- alu_out  in  16  ALU result
- alu_zr  in  1  ALU result is zero
- alu_ng  in  1  ALU result is negative
- out_m  out  16  memory write data (registered)
- address_m  out  PC_WIDTH  memory write address (registered)
- write_m  out  1  memory write request
- m_ack  in  1  memory write accepted
- pc  out  PC_WIDTH  program counter
- a_reg  out  16  A register
- d_reg  out  16  D register

## Operation
- FSM states are FETCH, EXEC and WMEM. Reset enters FETCH.
- FETCH:
  - instr_ready=1; an instruction is accepted when instr_valid & instr_ready.
  - A-instruction (instr[15]=0): a_reg<=instr, pc<=pc+1, state stays FETCH.
  - C-instruction (instr[15]=1): ir<=instr, state goes to EXEC. instr[14:13] are ignored.
- EXEC (instr_ready=0):
  - The ALU is evaluated combinationally from d_reg, a_reg/in_m and ir.
  - At the clock edge, destination writes are:
    - ir[5]: a_reg<=alu_out
    - ir[4]: d_reg<=alu_out
    - ir[3]: out_m<=alu_out, address_m<=a_reg[PC_WIDTH-1:0] (A value before this instruction's update)
  - Jump rule: taken = (ir[2]&alu_ng) | (ir[1]&alu_zr) | (ir[0]&~alu_ng&~alu_zr).
    - Taken: pc<=a_reg (old A).
    - Not taken: pc<=pc+1.
  - Next state: WMEM if ir[3], else FETCH.
- WMEM (instr_ready=0):
  - write_m=1; out_m and address_m are held.
  - On m_ack=1: write_m drops on that edge and state goes to FETCH.
  - m_ack high in the first WMEM cycle gives a one-cycle write.
- alu_x, alu_y and alu_ctl are continuously driven in every state. The ALU result is consumed only in EXEC.

## Timing
- Reset values while reset is high and after: state=FETCH, pc=RESET_PC, a_reg=0, d_reg=0, ir=0, out_m=0, address_m=0, write_m=0, instr_ready=1.
- Reset asserted mid-EXEC or mid-WMEM aborts the operation immediately, with no clock edge needed. write_m falls asynchronously.
- Latency from acceptance:
  - A-instruction: 1 cycle.
  - C-instruction without M write: 2 cycles; next acceptance is 2 cycles after the previous one.
  - C-instruction with M write: 2 cycles + WMEM cycles (at least 1).
- pc increments modulo 2^PC_WIDTH, so 0x7FFF+1 wraps to 0.
- Boundary cases:
  - instr_valid during EXEC/WMEM is ignored; the instruction must be held by the source.
  - m_ack outside WMEM is ignored.
  - Destination A and a jump in the same instruction: the jump target is the old a_reg.
  - Destination AM: address_m is the old a_reg.

## Test plan
- Reset: assert reset mid-run -> pc=0, a_reg=0, d_reg=0, write_m=0, instr_ready=1 without a clock edge.
- A-instruction 0x0005 accepted at pc=0 -> after 1 cycle a_reg=0x0005, pc=1, instr_ready stays 1.
- After @5, send 0xEC10 (D=A):
  - During EXEC: alu_ctl=6'b110000, alu_y=5, instr_ready=0.
  - After EXEC: d_reg=5, pc=2.
- With d_reg=5, a_reg=100, send 0xE7C8 (M=D+1), m_ack held low 3 cycles then high:
  - write_m=1, out_m=6, address_m=100, all stable through the wait.
  - write_m falls after the ack edge; FETCH resumes.
- a_reg=20, send 0xE302 (D;JEQ):
  - With d_reg=0 -> pc=20.
  - Repeat with d_reg=1 -> pc=old pc+1.
  - Also check JLT (0xE304) with d_reg=0xFFFF -> taken.
- pc wrap: reach pc=0x7FFF and accept an A-instruction -> pc=0. Assert reset during WMEM -> write_m=0 immediately, state FETCH.
